// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divider stream controller.
//   DIV_W        - operand/result width of the attached 10-bit divider
//   div_state_t  - controller FSM states
//   div_result_t - captured divider result plus frame tag
package div_pkg;

  localparam int DIV_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [DIV_W-1:0] quot;
    logic [DIV_W-1:0] rem;
    logic             div0;
    logic             last;
  } div_result_t;

endpackage

// File: rtl/div_stream_ctrl_div0_sat_counter.sv
// div0_sat_counter: saturating event counter with synchronous clear.
//   i_clk     - system clock
//   i_rst_n   - asynchronous active-low reset
//   i_clear   - synchronous clear, wins over i_inc
//   i_inc     - count one event
//   o_count   - current count, sticks at all-ones
module div0_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/div_stream_ctrl.sv
// div_stream_ctrl: registered valid/ready wrapper around an external
// combinational unsigned divider.
//   i_clk, i_rst_n            - clock, asynchronous active-low reset
//   i_clear                   - synchronous clear of o_div0_count
//   i_in_valid/o_in_ready     - input pair handshake
//   i_in_num/i_in_den/i_in_last - numerator, denominator, frame-last tag
//   o_div_a/o_div_b           - registered operands to the divider
//   i_div_quotient/i_div_remainder/i_div_by_0 - divider results
//   o_out_valid/i_out_ready   - result handshake
//   o_out_quot/o_out_rem/o_out_div0/o_out_last - registered result
//   o_frame_done              - pulse after an out_last result handshakes
//   o_div0_count              - saturating count of divide-by-zero results
//
// state | meaning
// IDLE  | no pair in flight, ready for input
// CALC  | operands on divider, result captured at end of cycle
// HOLD  | result presented, waiting for out_ready
module div_stream_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH  = DIV_W,
  parameter bit SAT_ON_DIV0 = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_num,
  input  logic [DATA_WIDTH-1:0] i_in_den,
  input  logic                  i_in_last,
  output logic [DATA_WIDTH-1:0] o_div_a,
  output logic [DATA_WIDTH-1:0] o_div_b,
  input  logic [DATA_WIDTH-1:0] i_div_quotient,
  input  logic [DATA_WIDTH-1:0] i_div_remainder,
  input  logic                  i_div_by_0,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_quot,
  output logic [DATA_WIDTH-1:0] o_out_rem,
  output logic                  o_out_div0,
  output logic                  o_out_last,
  output logic                  o_frame_done,
  output logic [CNT_WIDTH-1:0]  o_div0_count
);

  div_state_t            r_state;
  div_state_t            w_state_nxt;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] r_div_a;
  logic [DATA_WIDTH-1:0] r_div_b;
  logic                  r_last;
  div_result_t           r_res;
  logic                  r_out_valid;
  logic                  r_frame_done;

  // Gated by reset so upstream never sees ready while the block is held off.
  assign w_ready   = i_rst_n && ((r_state == IDLE) || ((r_state == HOLD) && i_out_ready));
  assign w_accept  = w_ready && i_in_valid;
  assign w_capture = (r_state == CALC);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    w_state_nxt = HOLD;
      HOLD:    if (i_out_ready) w_state_nxt = i_in_valid ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_div_a      <= '0;
      r_div_b      <= '0;
      r_last       <= 1'b0;
      r_res        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_div_a <= i_in_num;
        r_div_b <= i_in_den;
        r_last  <= i_in_last;
      end
      if (w_capture) begin
        r_res.quot <= (i_div_by_0 && SAT_ON_DIV0) ? {DATA_WIDTH{1'b1}} : i_div_quotient;
        r_res.rem  <= i_div_remainder;
        r_res.div0 <= i_div_by_0;
        r_res.last <= r_last;
      end
      // Valid exactly while the FSM sits in HOLD.
      r_out_valid  <= (w_state_nxt == HOLD);
      r_frame_done <= r_out_valid && i_out_ready && r_res.last;
    end
  end

  div0_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_div0_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_inc   (w_capture && i_div_by_0),
    .o_count (o_div0_count)
  );

  assign o_in_ready   = w_ready;
  assign o_div_a      = r_div_a;
  assign o_div_b      = r_div_b;
  assign o_out_valid  = r_out_valid;
  assign o_out_quot   = r_res.quot;
  assign o_out_rem    = r_res.rem;
  assign o_out_div0   = r_res.div0;
  assign o_out_last   = r_res.last;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_div_stream_ctrl.sv
// Bench for div_stream_ctrl. Three instances share one input stream:
//   u_a: SAT_ON_DIV0=1, CNT_WIDTH=16
//   u_b: SAT_ON_DIV0=0, CNT_WIDTH=16
//   u_c: SAT_ON_DIV0=1, CNT_WIDTH=2
// Each has its own behavioural divider. On a zero divisor the model returns
// ~a as quotient so saturation versus pass-through is observable.
module tb_div_stream_ctrl;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_num;
  logic [W-1:0] in_den;
  logic         in_last;
  logic         out_ready;

  logic         rdy_a, rdy_b, rdy_c;
  logic [W-1:0] da_a, db_a, da_b, db_b, da_c, db_c;
  logic [W-1:0] dq_a, dr_a, dq_b, dr_b, dq_c, dr_c;
  logic         dz_a, dz_b, dz_c;
  logic         ov_a, ov_b, ov_c;
  logic [W-1:0] oq_a, oq_b, oq_c, or_a, or_b, or_c;
  logic         o0_a, o0_b, o0_c, ol_a, ol_b, ol_c;
  logic         fd_a, fd_b, fd_c;
  logic [15:0]  cnt_a, cnt_b;
  logic [1:0]   cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign dz_a = (db_a == '0);
  assign dq_a = dz_a ? ~da_a : da_a / db_a;
  assign dr_a = dz_a ? da_a : da_a % db_a;
  assign dz_b = (db_b == '0);
  assign dq_b = dz_b ? ~da_b : da_b / db_b;
  assign dr_b = dz_b ? da_b : da_b % db_b;
  assign dz_c = (db_c == '0);
  assign dq_c = dz_c ? ~da_c : da_c / db_c;
  assign dr_c = dz_c ? da_c : da_c % db_c;

  div_stream_ctrl #(.DATA_WIDTH(W), .SAT_ON_DIV0(1'b1), .CNT_WIDTH(16)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_valid(in_valid), .o_in_ready(rdy_a),
    .i_in_num(in_num), .i_in_den(in_den), .i_in_last(in_last), .o_div_a(da_a), .o_div_b(db_a),
    .i_div_quotient(dq_a), .i_div_remainder(dr_a), .i_div_by_0(dz_a), .o_out_valid(ov_a),
    .i_out_ready(out_ready), .o_out_quot(oq_a), .o_out_rem(or_a), .o_out_div0(o0_a),
    .o_out_last(ol_a), .o_frame_done(fd_a), .o_div0_count(cnt_a));

  div_stream_ctrl #(.DATA_WIDTH(W), .SAT_ON_DIV0(1'b0), .CNT_WIDTH(16)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_valid(in_valid), .o_in_ready(rdy_b),
    .i_in_num(in_num), .i_in_den(in_den), .i_in_last(in_last), .o_div_a(da_b), .o_div_b(db_b),
    .i_div_quotient(dq_b), .i_div_remainder(dr_b), .i_div_by_0(dz_b), .o_out_valid(ov_b),
    .i_out_ready(out_ready), .o_out_quot(oq_b), .o_out_rem(or_b), .o_out_div0(o0_b),
    .o_out_last(ol_b), .o_frame_done(fd_b), .o_div0_count(cnt_b));

  div_stream_ctrl #(.DATA_WIDTH(W), .SAT_ON_DIV0(1'b1), .CNT_WIDTH(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_valid(in_valid), .o_in_ready(rdy_c),
    .i_in_num(in_num), .i_in_den(in_den), .i_in_last(in_last), .o_div_a(da_c), .o_div_b(db_c),
    .i_div_quotient(dq_c), .i_div_remainder(dr_c), .i_div_by_0(dz_c), .o_out_valid(ov_c),
    .i_out_ready(out_ready), .o_out_quot(oq_c), .o_out_rem(or_c), .o_out_div0(o0_c),
    .o_out_last(ol_c), .o_frame_done(fd_c), .o_div0_count(cnt_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] n, input logic [W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    in_last  = l;
  endtask

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic         l;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t stream [4];

  initial begin
    stream[0] = '{n: 10'd20,  d: 10'd4, l: 1'b0, q: 10'd5,   r: 10'd0};
    stream[1] = '{n: 10'd33,  d: 10'd5, l: 1'b0, q: 10'd6,   r: 10'd3};
    stream[2] = '{n: 10'd64,  d: 10'd8, l: 1'b0, q: 10'd8,   r: 10'd0};
    stream[3] = '{n: 10'd300, d: 10'd1, l: 1'b1, q: 10'd300, r: 10'd0};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_num = '0; in_den = '0;
    in_last = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(rdy_a), 0);
    chk("rst_out_valid", 32'(ov_a), 0);
    chk("rst_div_a", 32'(da_a), 0);
    chk("rst_out_quot", 32'(oq_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(rdy_a), 1);

    // 100/7
    drive(10'd100, 10'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("calc_out_valid", 32'(ov_a), 0);
    chk("calc_in_ready", 32'(rdy_a), 0);
    chk("calc_div_a", 32'(da_a), 100);
    chk("calc_div_b", 32'(db_a), 7);
    tick();
    chk("p1_valid", 32'(ov_a), 1);
    chk("p1_quot", 32'(oq_a), 14);
    chk("p1_rem", 32'(or_a), 2);
    chk("p1_div0", 32'(o0_a), 0);
    tick();
    chk("p1_drop", 32'(ov_a), 0);
    chk("p1_no_frame", 32'(fd_a), 0);

    // 1023/0
    drive(10'd1023, 10'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("dz_quot_sat", 32'(oq_a), 1023);
    chk("dz_div0", 32'(o0_a), 1);
    chk("dz_rem", 32'(or_a), 1023);
    chk("dz_count", 32'(cnt_a), 1);
    chk("dz_quot_raw", 32'(oq_b), 0);
    chk("dz_div0_raw", 32'(o0_b), 1);
    tick();

    // backpressure: 500/10 then 9/3
    out_ready = 1'b0;
    drive(10'd500, 10'd10, 1'b0);
    tick();
    drive(10'd9, 10'd3, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(ov_a), 1);
      chk("bp_quot", 32'(oq_a), 50);
      chk("bp_rem", 32'(or_a), 0);
      chk("bp_in_ready", 32'(rdy_a), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rdy_a), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_valid_drop", 32'(ov_a), 0);
    chk("bp_div_a", 32'(da_a), 9);
    tick();
    chk("bp2_valid", 32'(ov_a), 1);
    chk("bp2_quot", 32'(oq_a), 3);
    chk("bp2_rem", 32'(or_a), 0);
    tick();

    // four-pair frame, last one tagged
    for (int k = 0; k < 4; k++) begin
      drive(stream[k].n, stream[k].d, stream[k].l);
      tick();
      in_valid = 1'b0;
      chk("fr_no_frame", 32'(fd_a), 0);
      tick();
      chk("fr_valid", 32'(ov_a), 1);
      chk("fr_quot", 32'(oq_a), 32'(stream[k].q));
      chk("fr_rem", 32'(or_a), 32'(stream[k].r));
      chk("fr_last", 32'(ol_a), 32'(stream[k].l));
    end
    in_last = 1'b0;
    chk("fr_done_early", 32'(fd_a), 0);
    tick();
    chk("fr_done", 32'(fd_a), 1);
    chk("fr_drop", 32'(ov_a), 0);
    tick();
    chk("fr_done_once", 32'(fd_a), 0);

    // reset while HOLD with a tagged 77/7 pending
    out_ready = 1'b0;
    drive(10'd77, 10'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    tick();
    chk("mr_pending_quot", 32'(oq_a), 11);
    chk("mr_pending_valid", 32'(ov_a), 1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_valid", 32'(ov_a), 0);
    chk("mr_frame", 32'(fd_a), 0);
    chk("mr_quot", 32'(oq_a), 0);
    chk("mr_count", 32'(cnt_a), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_after_frame", 32'(fd_a), 0);
    drive(10'd45, 10'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_first_valid", 32'(ov_a), 1);
    chk("mr_first_quot", 32'(oq_a), 7);
    chk("mr_first_rem", 32'(or_a), 3);
    tick();

    // saturating div0 counter (2-bit on u_c)
    for (int k = 1; k <= 5; k++) begin
      drive(10'(k), 10'd0, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      chk("sat_count_c", 32'(cnt_c), (k > 3) ? 3 : k);
      chk("sat_count_a", 32'(cnt_a), 32'(k));
      tick();
    end
    drive(10'd6, 10'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count_c", 32'(cnt_c), 0);
    chk("clr_count_a", 32'(cnt_a), 0);
    chk("clr_div0", 32'(o0_c), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
